axil_load_master: RTL and testbench
===================================

Name: axil_load_master

Overview:
- AXI-Lite read initiator for the core's load path.
- Accepts one load request at a time: address, size and signedness.
- Issues a single AR/R transaction to a read responder such as the CLINT timer or UART.
- Extracts and sign- or zero-extends the addressed byte, half or word from the 32-bit read beat.
- Returns the result to the LSU through a valid/ready response channel, with error reporting for misalignment, bus error and timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in ADDR plus DATA before abort. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  load request valid
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- req_signed  in  1  1=sign-extend, 0=zero-extend
- resp_valid  out  1  response valid
- resp_ready  in  1  LSU accepts response
- resp_data  out  32  extended load data
- resp_err  out  2  00 ok, 01 bus error, 10 misaligned, 11 timeout
- m_araddr  out  32  AXI read address
- m_arvalid  out  1  AXI address valid
- m_arready  in  1  AXI address ready (tie high for responders without arready)
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI read data ready
- m_rdata  in  32  AXI read data
- m_rresp  in  2  AXI read response
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE. req_ready goes to 1 in the first cycle after reset deasserts.
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, size and signed. Clear the timeout counter.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with resp_err=10, resp_data=0. No bus transaction is issued.
  - Aligned request: go to ADDR.
- ADDR:
  - m_arvalid=1 and m_araddr=latched address (full byte address, unmodified).
  - m_araddr is held stable until handshake.
  - On m_arready, go to DATA.
- DATA:
  - m_rready=1, m_arvalid=0.
  - On m_rvalid, capture m_rdata and m_rresp, then go to RESP.
  - m_rvalid sampled in ADDR is ignored. R data must follow the AR handshake.
- RESP:
  - resp_valid=1. resp_data and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE. req_ready is high again the cycle after.
  - No back-to-back acceptance in the RESP cycle.
- Data extraction: shift = addr[1:0]*8, lane = m_rdata >> shift.
  - Byte: lane[7:0] extended to 32 bits.
  - Half: lane[15:0] extended to 32 bits.
  - Word: m_rdata unchanged. req_signed is ignored.
- Bus error: m_rresp != 00 gives resp_err=01, and resp_data is still the extracted value.
- Timeout:
  - The counter increments each cycle in ADDR or DATA.
  - When the count equals TIMEOUT_CYCLES (nonzero), abort: drop m_arvalid and m_rready, go to RESP with resp_err=11 and resp_data=0.
  - A handshake (m_arready in ADDR, m_rvalid in DATA) in the same cycle as expiry wins over the timeout.
- Latency: with responder arready=1 and rvalid one cycle after AR:
  - Request accepted at cycle 0.
  - m_arvalid at cycle 1.
  - m_rready at cycle 2, rvalid at cycle 2.
  - resp_valid at cycle 3.
  - Misaligned request: resp_valid at cycle 1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any in-flight bus transaction is abandoned; responders share the same reset.
- Only one outstanding transaction. The AR address is never changed while m_arvalid=1.

Test Plan:
- Aligned word load: addr=0x0200_0000, arready=1, rdata=0x1234_5678 one cycle after AR -> resp_valid at cycle 3, resp_data=0x1234_5678, resp_err=00.
- Signed byte load: addr=0xa000_0003, rdata=0x80FF_0011 -> resp_data=0xFFFF_FF80. Same access unsigned -> 0x0000_0080.
- Signed half load: addr=0x...2, rdata=0x9ABC_0000 -> resp_data=0xFFFF_9ABC.
- Misaligned: word at 0x...2 -> no m_arvalid ever, resp_valid at cycle 1, resp_err=10.
- Backpressure: arready low 3 cycles, rvalid delayed 2 cycles, resp_ready low 4 cycles -> araddr stable throughout, single AR handshake, resp_data held until resp_ready, correct data.
- Timeout and error:
  - TIMEOUT_CYCLES=4 with arready stuck low -> m_arvalid drops, resp_err=11.
  - m_rresp=10 -> resp_err=01.
  - reset asserted in DATA -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/axil_load_master.sv
// axil_load_master: AXI-Lite read initiator for the core's load path.
// Takes one load request at a time, issues a single AR/R transaction,
// extracts and extends the addressed byte/half/word from the 32-bit read
// beat and returns it over a valid/ready response channel with error status.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               load request (addr, size 0=B 1=H 2/3=W, signed)
//   resp_*              load response (data, err 00 ok/01 bus/10 misaligned/11 timeout)
//   m_ar*, m_r*         AXI-Lite read address and read data channels
//   busy                high whenever the master is not idle
module axil_load_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 16;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_BUS = 2'b01;
  localparam logic [1:0] ERR_MIS = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  // Last counter value before the cycle budget is used up.
  localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;

  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [1:0]          resp_err_q, resp_err_d;
  logic [31:0]         araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic                misalign_c;
  logic                expire_c;
  logic [4:0]          shamt_c;
  logic [LANE_W-1:0]   lane_c;
  logic [DATA_W-1:0]   ext_c;

  assign accept_c   = (state_q == S_IDLE) && req_valid && req_ready_q;
  // Reserved size 3 is treated as a word for alignment as well as extraction.
  assign misalign_c = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  // Budget spent in ADDR+DATA counts the current cycle, hence TMO_LAST.
  assign expire_c   = TMO_EN && (cnt_q >= TMO_LAST);

  // Lane extraction from the read beat.
  assign shamt_c = {addr_lo_q, 3'b000};
  assign lane_c  = LANE_W'(m_rdata >> shamt_c);

  always_comb begin
    case (size_q)
      2'd0:    ext_c = {{24{signed_q & lane_c[7]}}, lane_c[7:0]};
      2'd1:    ext_c = {{16{signed_q & lane_c[15]}}, lane_c};
      default: ext_c = m_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a handshake always wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = misalign_c ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_arready) begin
          state_d = S_DATA;
        end else if (expire_c) begin
          state_d = S_RESP;
        end
      end
      S_DATA: begin
        if (m_rvalid) begin
          state_d = S_RESP;
        end else if (expire_c) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags follow the next state
  // so that every output is a flop.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_ADDR);
    rready_d     = (state_d == S_DATA);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);

    araddr_d     = araddr_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          addr_lo_d = req_addr[1:0];
          size_d    = req_size;
          signed_d  = req_signed;
          cnt_d     = '0;
          if (misalign_c) begin
            resp_data_d = '0;
            resp_err_d  = ERR_MIS;
          end else begin
            araddr_d = req_addr;
          end
        end
      end
      S_ADDR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!m_arready && expire_c) begin
          resp_data_d = '0;
          resp_err_d  = ERR_TMO;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (m_rvalid) begin
          resp_data_d = ext_c;
          resp_err_d  = (m_rresp != 2'b00) ? ERR_BUS : ERR_OK;
        end else if (expire_c) begin
          resp_data_d = '0;
          resp_err_d  = ERR_TMO;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_data_d = '0;
          resp_err_d  = ERR_OK;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      araddr_q     <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= ERR_OK;
      addr_lo_q    <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      araddr_q     <= araddr_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign m_araddr   = araddr_q;
  assign m_arvalid  = arvalid_q;
  assign m_rready   = rready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_axil_load_master.sv
// tb_axil_load_master: scoreboard bench for axil_load_master with a
// delay-programmable AXI-Lite read responder and LSU response sink.
module tb_axil_load_master;

  localparam int unsigned TMO   = 8;
  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        busy;

  axil_load_master #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_signed(req_signed),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Responder / sink programming.
  int          ar_dly = 0, r_dly = 0, rr_dly = 0;
  logic [31:0] rsp_rdata = '0;
  logic [1:0]  rsp_rresp = '0;
  int          ar_w, r_w, rr_w;

  // Monitor state.
  logic [33:0] exp_q[$];
  logic [33:0] e;
  int          ar_hs, ar_cyc, resp_cyc, t0;
  bit          saw_ar, done, ar_pend, resp_pend;
  logic [31:0] ar_prev, hold_d;
  logic [1:0]  hold_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference load result {err, data}.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [1:0] sz,
                                        input logic sg, input logic [31:0] d,
                                        input logic [1:0] rr);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    if ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00)) return {2'b10, 32'h0};
    case (a[1:0])
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'd0:    v = sg ? 32'($signed(b)) : {24'h0, b};
      2'd1:    v = sg ? 32'($signed(h)) : {16'h0, h};
      default: v = d;
    endcase
    return {((rr != 2'b00) ? 2'b01 : 2'b00), v};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI-Lite responder and LSU sink, each with a programmable stall.
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; resp_ready = 1'b0;
    m_rdata = '0; m_rresp = '0; ar_w = 0; r_w = 0; rr_w = 0;
    forever begin
      @(posedge clk); #1;
      if (!m_arvalid) ar_w = 0;
      m_arready = m_arvalid && (ar_w >= ar_dly);
      if (m_arvalid) ar_w++;
      if (!m_rready) r_w = 0;
      m_rvalid = m_rready && (r_w >= r_dly);
      if (m_rready) r_w++;
      m_rdata = m_rvalid ? rsp_rdata : 32'hDEAD_BEEF;
      m_rresp = m_rvalid ? rsp_rresp : 2'b00;
      if (!resp_valid) rr_w = 0;
      resp_ready = resp_valid && (rr_w >= rr_dly);
      if (resp_valid) rr_w++;
    end
  end

  // Monitor: protocol stability and scoreboard compare on response handshake.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      ar_pend = 0; resp_pend = 0;
    end else begin
      if (m_arvalid && !saw_ar) begin saw_ar = 1; ar_cyc = cyc; end
      if (m_arvalid && m_arready) ar_hs++;
      if (ar_pend && m_arvalid) chk("araddr_stable", m_araddr, ar_prev);
      ar_pend = m_arvalid && !m_arready;
      ar_prev = m_araddr;
      if (resp_pend) begin
        chk("resp_valid_hold", 32'(resp_valid), 1);
        chk("resp_data_hold", resp_data, hold_d);
        chk("resp_err_hold", 32'(resp_err), 32'(hold_e));
      end
      resp_pend = resp_valid && !resp_ready;
      hold_d = resp_data;
      hold_e = resp_err;
      if (resp_valid && resp_cyc < 0) resp_cyc = cyc;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e[31:0]);
          chk("resp_err", 32'(resp_err), 32'(e[33:32]));
        end
        done = 1;
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [31:0] d, input logic [1:0] rr,
                         input int ar_d, input int r_d, input int rr_d,
                         input logic [33:0] exp, input int exp_lat, input int exp_hs);
    int n;
    @(posedge clk); #1;
    ar_dly = ar_d; r_dly = r_d; rr_dly = rr_d; rsp_rdata = d; rsp_rresp = rr;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      chk("req_ready_wait", 32'(req_ready), 1);
      return;
    end
    saw_ar = 0; ar_hs = 0; ar_cyc = -1; resp_cyc = -1; done = 0;
    exp_q.push_back(exp);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_signed = sg;
    t0 = cyc;
    @(posedge clk); #1;
    // Scramble request fields so only latched values can produce the result.
    req_valid = 1'b0; req_addr = $urandom; req_size = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    if (!done) begin
      chk("resp_wait", 32'(done), 1);
      exp_q.delete();
      return;
    end
    if (exp_lat >= 0) chk("resp_latency", 32'(resp_cyc - t0), 32'(exp_lat));
    chk("ar_handshakes", 32'(ar_hs), 32'(exp_hs));
  endtask

  logic [31:0] ra, rdv;
  logic [1:0]  rsz, rrr;
  logic        rsg;
  int          rard, rrd, rrrd;
  logic [33:0] rexp;

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({req_ready, resp_valid, m_arvalid, m_rready, busy, resp_err}), 0);
    chk("rst_data", resp_data, 0);
    chk("rst_araddr", m_araddr, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("req_ready_after_rst", 32'(req_ready), 1);

    // Directed loads.
    do_load(32'h0200_0000, 2'd2, 1'b0, 32'h1234_5678, 2'b00, 0, 0, 0, {2'b00, 32'h1234_5678}, 3, 1);
    chk("ar_latency", 32'(ar_cyc - t0), 1);
    do_load(32'hA000_0003, 2'd0, 1'b1, 32'h80FF_0011, 2'b00, 0, 0, 0, {2'b00, 32'hFFFF_FF80}, 3, 1);
    do_load(32'hA000_0003, 2'd0, 1'b0, 32'h80FF_0011, 2'b00, 0, 0, 0, {2'b00, 32'h0000_0080}, 3, 1);
    do_load(32'hA000_0002, 2'd1, 1'b1, 32'h9ABC_0000, 2'b00, 0, 0, 0, {2'b00, 32'hFFFF_9ABC}, 3, 1);
    do_load(32'hA000_0000, 2'd1, 1'b0, 32'h1234_8765, 2'b00, 0, 0, 0, {2'b00, 32'h0000_8765}, 3, 1);
    do_load(32'hA000_0001, 2'd0, 1'b1, 32'h0000_7F00, 2'b00, 0, 0, 0, {2'b00, 32'h0000_007F}, 3, 1);
    do_load(32'hA000_0004, 2'd3, 1'b1, 32'h8000_0001, 2'b00, 0, 0, 0, {2'b00, 32'h8000_0001}, 3, 1);

    // Misaligned: no bus traffic at all.
    do_load(32'h0200_0002, 2'd2, 1'b0, 32'h1111_1111, 2'b00, 0, 0, 0, {2'b10, 32'h0}, 1, 0);
    chk("misaligned_no_ar", 32'(saw_ar), 0);
    do_load(32'h0200_0001, 2'd1, 1'b1, 32'h1111_1111, 2'b00, 0, 0, 0, {2'b10, 32'h0}, 1, 0);
    chk("misaligned_no_ar", 32'(saw_ar), 0);

    // Backpressure on AR, R and response.
    do_load(32'h4000_0010, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b00, 3, 2, 4, {2'b00, 32'hCAFE_F00D}, 8, 1);

    // Bus error still returns extracted data.
    do_load(32'h4000_0001, 2'd0, 1'b0, 32'h0000_AB00, 2'b10, 0, 0, 0, {2'b01, 32'h0000_00AB}, 3, 1);

    // Timeouts in ADDR and in DATA, then handshakes exactly at expiry.
    do_load(32'h5000_0000, 2'd2, 1'b0, 32'h7777_7777, 2'b00, 1000, 0, 0, {2'b11, 32'h0}, TMO + 1, 0);
    chk("tmo_arvalid_low", 32'(m_arvalid), 0);
    do_load(32'h5000_0004, 2'd2, 1'b0, 32'h7777_7777, 2'b00, 0, 1000, 1, {2'b11, 32'h0}, TMO + 1, 1);
    do_load(32'h5000_0008, 2'd2, 1'b0, 32'h3C3C_A5A5, 2'b00, TMO - 1, 0, 0, {2'b00, 32'h3C3C_A5A5}, TMO + 2, 1);

    // Reset while waiting in DATA.
    @(posedge clk); #1;
    ar_dly = 0; r_dly = 1000; rr_dly = 0;
    exp_q.push_back({2'b00, 32'h0});
    req_valid = 1'b1; req_addr = 32'h1000_0000; req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!m_rready && n < 20) begin @(posedge clk); #1; n++; end
    chk("reached_data", 32'(m_rready), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ctrl", 32'({req_ready, resp_valid, m_arvalid, m_rready, busy, resp_err}), 0);
    chk("rst_mid_data", resp_data, 0);
    chk("rst_mid_araddr", m_araddr, 0);
    reset = 1'b0;
    exp_q.delete();
    r_dly = 0;
    @(posedge clk); #1;
    chk("req_ready_after_rst2", 32'(req_ready), 1);
    do_load(32'h0200_0000, 2'd2, 1'b0, 32'hFEED_0001, 2'b00, 0, 0, 0, {2'b00, 32'hFEED_0001}, 3, 1);

    // Random loads, mostly aligned.
    for (int i = 0; i < 16; i++) begin
      ra   = $urandom;
      rsz  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        else if (rsz[1]) ra[1:0] = 2'b00;
      end
      rsg  = 1'($urandom_range(0, 1));
      rdv  = $urandom;
      rrr  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rard = $urandom_range(0, 2);
      rrd  = $urandom_range(0, 2);
      rrrd = $urandom_range(0, 3);
      rexp = model(ra, rsz, rsg, rdv, rrr);
      if (rexp[33:32] == 2'b10)
        do_load(ra, rsz, rsg, rdv, rrr, rard, rrd, rrrd, rexp, 1, 0);
      else
        do_load(ra, rsz, rsg, rdv, rrr, rard, rrd, rrrd, rexp, 3 + rard + rrd, 1);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("idle_at_end", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
